// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between fetch and LSU.
// One transaction in flight; data wins ties unless fetch has been starved.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2,
  parameter int STARVE  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_wen,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE);

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] streak;
  logic       owner;
  logic       wen_q;
  logic       idle;
  logic       starved;

  assign idle    = (state == IDLE) && !reset;
  assign starved = (streak == SMAX);

  assign if_gnt = idle && if_req
               && (!d_req || starved);
  assign d_gnt  = idle && d_req
               && !(if_req && starved);

  // the write strobe is only ever visible alongside the command strobe
  assign mem_wen = mem_en && wen_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      streak    <= '0;
      owner     <= OWN_IF;
      wen_q     <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_gnt) begin
            owner    <= OWN_IF;
            wen_q    <= 1'b0;
            mem_addr <= if_addr;
            mem_en   <= 1'b1;
            streak   <= '0;
            state    <= ISSUE;
          end else if (d_gnt) begin
            owner     <= OWN_D;
            wen_q     <= d_wen;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_en    <= 1'b1;
            state     <= ISSUE;
            if (!if_req)
              streak <= '0;
            else if (!starved)
              streak <= streak + 4'd1;
          end
        end
        ISSUE: begin
          cnt   <= LAT;
          state <= wen_q ? IDLE : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            if (owner == OWN_D) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, corner sequences and random traffic
// checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int LAT    = 2;
  localparam int STARVE = 4;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z = '0;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance (MEM_LAT=2)
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_arbiter #(
    .AW(32), .DW(32),
    .MEM_LAT(LAT), .STARVE(STARVE)
  ) u_dut (
    .clk(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_wen(d_wen),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // boundary instance (MEM_LAT=1)
  logic        b_rst;
  logic        b_if_req;
  logic [31:0] b_if_addr;
  logic        b_if_gnt;
  logic        b_if_rvalid;
  logic [31:0] b_if_rdata;
  logic        b_zero = 1'b0;
  logic [31:0] b_zero32 = '0;
  logic        b_d_gnt;
  logic        b_d_rvalid;
  logic [31:0] b_d_rdata;
  logic        b_mem_en;
  logic        b_mem_wen;
  logic [31:0] b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [31:0] b_mem_rdata;

  mem_arbiter #(
    .AW(32), .DW(32),
    .MEM_LAT(1), .STARVE(STARVE)
  ) u_lat1 (
    .clk(clk), .reset(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr),
    .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
    .if_rdata(b_if_rdata),
    .d_req(b_zero), .d_wen(b_zero),
    .d_addr(b_zero32), .d_wdata(b_zero32),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid),
    .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_wen(b_mem_wen),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  function automatic logic [31:0] init_val(
    input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5A5A_5A5A;
  endfunction

  // memory macros: data valid only in the one cycle it is due
  logic [31:0] env_mem [logic [31:0]];
  int          due_a = -1;
  logic [31:0] due_da;
  int          due_b = -1;
  logic [31:0] due_db;

  initial forever begin
    @(negedge clk);
    if (mem_en) begin
      if (mem_wen) begin
        env_mem[mem_addr] = mem_wdata;
      end else begin
        due_a  = cyc + LAT;
        due_da = env_mem.exists(mem_addr)
               ? env_mem[mem_addr]
               : init_val(mem_addr);
      end
    end
    mem_rdata = (cyc == due_a) ? due_da
              : (32'hBAD0_0000 ^ 32'(cyc));
  end

  initial forever begin
    @(negedge clk);
    if (b_mem_en && !b_mem_wen) begin
      due_b  = cyc + 1;
      due_db = init_val(b_mem_addr);
    end
    b_mem_rdata = (cyc == due_b) ? due_db
                : (32'h0BAD_0000 ^ 32'(cyc));
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %b want %b",
               nm, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h want %h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst    = 1'b1;
    if_req = 1'b0;
    d_req  = 1'b0;
    d_wen  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        ifr;
    logic [31:0] ifa;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        eig;
    logic        edg;
    logic        emen;
    logic        emw;
    logic [31:0] ema;
    logic [31:0] emd;
    logic        eirv;
    logic        edrv;
    logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic ir,
    input logic [31:0] ia,
    input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dd,
    input logic eig, input logic edg,
    input logic emen, input logic emw,
    input logic [31:0] ema, input logic [31:0] emd,
    input logic eirv, input logic edrv,
    input logic [31:0] erd);
    vec_t v;
    v.rst = r;    v.ifr = ir;   v.ifa = ia;
    v.dr = dr;    v.dw = dw;    v.da = da;
    v.dd = dd;    v.eig = eig;  v.edg = edg;
    v.emen = emen; v.emw = emw; v.ema = ema;
    v.emd = emd;  v.eirv = eirv; v.edrv = edrv;
    v.erd = erd;
    return v;
  endfunction

  localparam int NV = 18;
  vec_t vt [NV];
  vec_t nil;

  // random-phase reference state
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] iss_addr [int];
  logic        iss_wen [int];
  logic [31:0] iss_wd [int];
  logic [31:0] exp_if [int];
  logic [31:0] exp_d [int];
  int          free_at;
  int          streak;
  logic        if_pend;
  logic        d_pend;
  logic        eig;
  logic        edg;
  logic        ebusy;
  logic [9:0]  pat;
  int          ng;
  int          lat;
  logic        found;

  function automatic logic [31:0] rmem(
    input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a]
                             : init_val(a);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; b_rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_wen = 1'b0;
    d_addr = '0; d_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0;
    env_mem[32'h40]  = 32'hDEAD_BEEF;
    env_mem[32'h200] = 32'hCAFE_F00D;
    env_mem[32'h0]   = 32'h1357_9BDF;

    repeat (2) @(negedge clk);
    chk1("rst mem_en", mem_en, L);
    chk1("rst mem_wen", mem_wen, L);
    chk32("rst mem_addr", mem_addr, Z);
    chk32("rst mem_wdata", mem_wdata, Z);
    chk32("rst if_rdata", if_rdata, Z);
    chk32("rst d_rdata", d_rdata, Z);
    chk1("rst if_rvalid", if_rvalid, L);
    chk1("rst d_rvalid", d_rvalid, L);
    chk1("rst b_d_gnt", b_d_gnt, L);
    chk32("rst b_d_rdata", b_d_rdata, Z);
    chk32("rst b_mem_wdata", b_mem_wdata, Z);

    // fetch read, data write, then simultaneous requests
    nil = mk(L,L,Z, L,L,Z,Z, L,L,L,L,Z,Z, L,L,Z);
    vt[0]  = mk(H,H,32'h40, L,L,Z,Z,
                L,L,L,L,Z,Z, L,L,Z);
    vt[1]  = mk(L,H,32'h40, L,L,Z,Z,
                H,L,L,L,Z,Z, L,L,Z);
    vt[2]  = mk(L,L,Z, L,L,Z,Z,
                L,L,H,L,32'h40,Z, L,L,Z);
    vt[3]  = nil;
    vt[4]  = nil;
    vt[5]  = mk(L,L,Z, L,L,Z,Z,
                L,L,L,L,Z,Z, H,L,32'hDEAD_BEEF);
    vt[6]  = mk(L,L,Z, H,H,32'h100,32'h1234_5678,
                L,H,L,L,Z,Z, L,L,Z);
    vt[7]  = mk(L,L,Z, L,L,Z,Z,
                L,L,H,H,32'h100,32'h1234_5678,
                L,L,Z);
    vt[8]  = mk(L,H,Z, H,L,32'h200,Z,
                L,H,L,L,Z,Z, L,L,Z);
    vt[9]  = mk(L,H,Z, L,L,Z,Z,
                L,L,H,L,32'h200,Z, L,L,Z);
    vt[10] = mk(L,H,Z, L,L,Z,Z,
                L,L,L,L,Z,Z, L,L,Z);
    vt[11] = vt[10];
    vt[12] = mk(L,H,Z, L,L,Z,Z,
                L,L,L,L,Z,Z, L,H,32'hCAFE_F00D);
    vt[13] = mk(L,H,Z, L,L,Z,Z,
                H,L,L,L,Z,Z, L,L,Z);
    vt[14] = mk(L,L,Z, L,L,Z,Z,
                L,L,H,L,Z,Z, L,L,Z);
    vt[15] = nil;
    vt[16] = nil;
    vt[17] = mk(L,L,Z, L,L,Z,Z,
                L,L,L,L,Z,Z, H,L,32'h1357_9BDF);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      rst     = vt[i].rst;
      if_req  = vt[i].ifr;
      if_addr = vt[i].ifa;
      d_req   = vt[i].dr;
      d_wen   = vt[i].dw;
      d_addr  = vt[i].da;
      d_wdata = vt[i].dd;
      @(negedge clk);
      chk1($sformatf("v%0d if_gnt", i),
           if_gnt, vt[i].eig);
      chk1($sformatf("v%0d d_gnt", i),
           d_gnt, vt[i].edg);
      chk1($sformatf("v%0d mem_en", i),
           mem_en, vt[i].emen);
      chk1($sformatf("v%0d mem_wen", i),
           mem_wen, vt[i].emw);
      chk1($sformatf("v%0d if_rvalid", i),
           if_rvalid, vt[i].eirv);
      chk1($sformatf("v%0d d_rvalid", i),
           d_rvalid, vt[i].edrv);
      if (vt[i].emen)
        chk32($sformatf("v%0d mem_addr", i),
              mem_addr, vt[i].ema);
      if (vt[i].emen && vt[i].emw)
        chk32($sformatf("v%0d mem_wdata", i),
              mem_wdata, vt[i].emd);
      if (vt[i].eirv)
        chk32($sformatf("v%0d if_rdata", i),
              if_rdata, vt[i].erd);
      if (vt[i].edrv)
        chk32($sformatf("v%0d d_rdata", i),
              d_rdata, vt[i].erd);
    end

    // starvation: both held, data always writing
    do_reset();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_wen = 1'b1;
    d_addr = 32'h300; d_wdata = 32'h1;
    pat = 10'b10000_10000;
    ng = 0;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        chk1($sformatf("starve onehot %0d", ng),
             if_gnt && d_gnt, L);
        chk1($sformatf("starve grant %0d", ng),
             if_gnt, pat[ng]);
        ng++;
      end
    end
    chk32("starve grants seen", 32'(ng), 32'd10);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;

    // reset while the read is waiting on memory
    do_reset();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk1("rmid gnt", if_gnt, H);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk1("rmid issue", mem_en, H);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1("rmid mem_en", mem_en, L);
      chk1("rmid if_rvalid", if_rvalid, L);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk1("post mem_en", mem_en, L);
      chk1("post if_rvalid", if_rvalid, L);
      chk1("post d_rvalid", d_rvalid, L);
      @(posedge clk); #1;
    end
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk1("fresh gnt", if_gnt, H);
    @(posedge clk); #1;
    if_req = 1'b0;
    found = 1'b0; lat = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (if_rvalid) begin
        found = 1'b1;
        lat = c;
      end
    end
    chk32("fresh latency", 32'(lat), 32'd4);
    chk32("fresh rdata", if_rdata, 32'hDEAD_BEEF);

    // MEM_LAT=1 boundary on the second instance
    @(posedge clk); #1;
    b_rst = 1'b0;
    b_if_req = 1'b1; b_if_addr = 32'h44;
    @(negedge clk);
    chk1("l1 gnt", b_if_gnt, H);
    @(posedge clk); #1;
    b_if_req = 1'b0;
    @(negedge clk);
    chk1("l1 mem_en", b_mem_en, H);
    chk1("l1 mem_wen", b_mem_wen, L);
    chk32("l1 mem_addr", b_mem_addr, 32'h44);
    @(negedge clk);
    chk1("l1 T2 rvalid", b_if_rvalid, L);
    @(negedge clk);
    chk1("l1 T3 rvalid", b_if_rvalid, H);
    chk32("l1 T3 rdata", b_if_rdata, init_val(32'h44));
    chk1("l1 T3 d_rvalid", b_d_rvalid, L);
    @(negedge clk);
    chk1("l1 T4 rvalid", b_if_rvalid, L);

    // randomized traffic against the transaction model
    do_reset();
    free_at = 0; streak = 0;
    if_pend = 1'b0; d_pend = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        if_addr = 32'h1000
                + ($urandom_range(0, 7) << 2);
      end
      if (!d_pend && $urandom_range(0, 1) == 0) begin
        d_pend  = 1'b1;
        d_wen   = 1'($urandom_range(0, 1));
        d_addr  = 32'h1000
                + ($urandom_range(0, 7) << 2);
        d_wdata = $urandom;
      end
      if_req = if_pend;
      d_req  = d_pend;
      @(negedge clk);
      ebusy = (cyc < free_at);
      eig = !ebusy && if_pend
         && (!d_pend || streak == STARVE);
      edg = !ebusy && d_pend && !eig;
      chk1("rnd if_gnt", if_gnt, eig);
      chk1("rnd d_gnt", d_gnt, edg);
      chk1("rnd mem_en", mem_en,
           iss_addr.exists(cyc));
      if (iss_addr.exists(cyc)) begin
        chk32("rnd mem_addr", mem_addr,
              iss_addr[cyc]);
        chk1("rnd mem_wen", mem_wen,
             iss_wen[cyc]);
        if (iss_wen[cyc])
          chk32("rnd mem_wdata", mem_wdata,
                iss_wd[cyc]);
      end
      chk1("rnd if_rvalid", if_rvalid,
           exp_if.exists(cyc));
      if (exp_if.exists(cyc))
        chk32("rnd if_rdata", if_rdata,
              exp_if[cyc]);
      chk1("rnd d_rvalid", d_rvalid,
           exp_d.exists(cyc));
      if (exp_d.exists(cyc))
        chk32("rnd d_rdata", d_rdata,
              exp_d[cyc]);
      if (eig) begin
        streak = 0;
        iss_addr[cyc + 1] = if_addr;
        iss_wen[cyc + 1]  = 1'b0;
        exp_if[cyc + 2 + LAT] = rmem(if_addr);
        free_at = cyc + 3 + LAT;
        if_pend = 1'b0;
      end else if (edg) begin
        if (!if_pend)
          streak = 0;
        else if (streak < STARVE)
          streak = streak + 1;
        iss_addr[cyc + 1] = d_addr;
        iss_wen[cyc + 1]  = d_wen;
        iss_wd[cyc + 1]   = d_wdata;
        if (d_wen) begin
          ref_mem[d_addr] = d_wdata;
          free_at = cyc + 2;
        end else begin
          exp_d[cyc + 2 + LAT] = rmem(d_addr);
          free_at = cyc + 3 + LAT;
        end
        d_pend = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory port between the core's instruction-fetch requester and its load/store requester. One transaction is in flight at a time, and data accesses have priority. A starvation guard forces a fetch grant after a run of data grants. Sits between the core's fetch/LSU logic and the memory macro, which has fixed read latency.

## Interface

Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `MEM_LAT`, 2, cycles from the issue cycle (`mem_en` high) to `mem_rdata` valid; legal range 1..7.
- `STARVE`, 4, consecutive data grants with a fetch pending before fetch is forced; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr`  in  AW  fetch address.
- `if_gnt`  out  1  fetch request accepted this cycle (combinational).
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  DW  fetch read data (registered).
- `d_req`  in  1  data request; held with `d_wen`/`d_addr`/`d_wdata` stable until `d_gnt`.
- `d_wen`  in  1  1 = write, 0 = read.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  write data.
- `d_gnt`  out  1  data request accepted this cycle (combinational).
- `d_rvalid`  out  1  one-cycle pulse on read completion only.
- `d_rdata`  out  DW  data read data (registered).
- `mem_en`  out  1  memory command strobe.
- `mem_wen`  out  1  memory write enable; only meaningful when `mem_en` is high.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; valid `MEM_LAT` cycles after the issue cycle.

## Operation

- FSM states and transitions:
  - IDLE: arbitrates; on a grant it captures the winner's cmd/addr/wdata and goes to ISSUE. No request → stays in IDLE.
  - ISSUE: drives `mem_en=1` plus the captured cmd for exactly one cycle. Write → IDLE. Read → WAIT, with a down-counter loaded to `MEM_LAT`.
  - WAIT: counter decrements each cycle. In the cycle where counter==1, `mem_rdata` is registered into the owner's rdata register, and the next state is RESP.
  - RESP: the owner's `rvalid` is high for one cycle; next state is IDLE.
- Arbitration happens only in IDLE; grants are gated by `~reset`.
  - Only one requester → that requester is granted.
  - Both requesting → data wins, unless `streak == STARVE`, in which case fetch wins.
- Streak counter (saturating at `STARVE`):
  - Fetch grant → cleared to 0.
  - Data grant with `if_req=1` → increments.
  - Data grant with `if_req=0` → cleared to 0.
- Owner bit: records which requester was granted; it steers `rvalid` and the rdata register.
- Non-owner outputs:
  - `rvalid` stays 0.
  - The non-owner's rdata register holds its previous value.
- `mem_addr`/`mem_wdata`/`mem_wen` hold the captured values from grant until the next grant. `mem_wen` is forced to 0 whenever `mem_en` is 0.
- Writes produce no `rvalid`; completion is implied by leaving ISSUE.

## Timing

- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - State → IDLE, streak → 0, counter → 0, owner → fetch.
  - All outputs → 0: `mem_en`, `mem_wen`, `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata`, both `rvalid`s, both `gnt`s.
- Reset mid-transaction: the transaction is abandoned. No `rvalid` is produced, `mem_en` drops immediately, and the first grant after deassert is normal.
- Read latency (grant in cycle T):
  - Issue in T+1.
  - `mem_rdata` sampled at the end of T+1+`MEM_LAT`.
  - `rvalid` and `rdata` in T+2+`MEM_LAT`.
  - Next grant possible in T+3+`MEM_LAT`.
- Write: grant in T, issue in T+1, next grant possible in T+2.
- `MEM_LAT=1`: WAIT lasts one cycle; `rvalid` in T+3.
- Requests asserted in a non-IDLE state wait; `gnt` is never asserted outside IDLE.
- A request dropped before `gnt` is a protocol violation; the arbiter ignores it and does not check for it.

## Test plan

- Fetch read, `MEM_LAT=2`:
  - Stimulus: `if_req`, `if_addr=0x40` at T0; memory returns 0xDEADBEEF in T3.
  - Response: `if_gnt` in T0; `mem_en=1`, `mem_addr=0x40`, `mem_wen=0` in T1; `if_rvalid=1`, `if_rdata=0xDEADBEEF` in T4; `d_rvalid` stays 0.
- Data write:
  - Stimulus: `d_req`, `d_wen=1`, `d_addr=0x100`, `d_wdata=0x12345678` at T0.
  - Response: `d_gnt` in T0; `mem_en`, `mem_wen`, 0x100/0x12345678 in T1; `mem_en=0` in T2; no `rvalid`; a new grant is possible in T2.
- Simultaneous requests at T0 (data read 0x200, fetch 0x0):
  - `d_gnt` in T0; `d_rvalid` in T4.
  - `if_gnt` in T5; `if_rvalid` in T9 with the fetch data.
- Starvation, `STARVE=4`:
  - Stimulus: both `if_req` and `d_req` held high continuously, all writes.
  - Response: grant order D,D,D,D,F,D,D,D,D,F.
- Reset mid-read:
  - Stimulus: assert `reset` in the WAIT state.
  - Response: `mem_en`/`rvalid` are 0 and stay 0. After deassert, a fresh fetch completes with correct data and latency.
- Boundary, `MEM_LAT=1`:
  - Stimulus: fetch read.
  - Response: `rvalid` in T3. Memory data driven only in T2 is captured correctly.
